// File: rtl/pipe_elastic.sv
// Valid/ready elastic delay line: PIP_D flow-controlled stages that collapse bubbles.
// Define PIPE_ELASTIC_SKID_EN to add a one-entry input skid buffer that registers in_ready.
module pipe_elastic #(
    parameter int REG_W = 1,
    parameter int PIP_D = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REG_W-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [REG_W-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(PIP_D+2)-1:0]   count
);
    localparam int CW = $clog2(PIP_D+2);

    logic [REG_W-1:0] data_q [PIP_D];
    logic [REG_W-1:0] data_d [PIP_D];
    logic [PIP_D-1:0] vld_q;
    logic [PIP_D-1:0] vld_d;
    logic [PIP_D-1:0] adv;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             in_fire;
    logic             out_fire;
    logic             src_vld;
    logic [REG_W-1:0] src_data;

    // adv[i]: stage i can take new content this edge (empty, or its word moves on)
    always_comb begin : ready_chain
        logic nxt;
        nxt = out_ready;
        for (int i = PIP_D - 1; i >= 0; i--) begin
            nxt    = !vld_q[i] || nxt;
            adv[i] = nxt;
        end
    end

`ifdef PIPE_ELASTIC_SKID_EN
    logic             skid_vld_q;
    logic             skid_vld_d;
    logic [REG_W-1:0] skid_data_q;
    logic [REG_W-1:0] skid_data_d;

    assign in_ready = rst_n && !skid_vld_q;
    assign in_fire  = in_valid && in_ready;
    assign src_vld  = skid_vld_q || in_fire;
    assign src_data = skid_vld_q ? skid_data_q : in_data;

    // Skid only fills when the whole pipe is stuck; it drains first once stage 0 frees.
    always_comb begin
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (skid_vld_q) begin
            if (adv[0]) begin
                skid_vld_d = 1'b0;
            end
        end else if (in_fire && !adv[0]) begin
            skid_vld_d  = 1'b1;
            skid_data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end
`else
    assign in_ready = rst_n && adv[0];
    assign in_fire  = in_valid && in_ready;
    assign src_vld  = in_fire;
    assign src_data = in_data;
`endif

    assign out_fire = vld_q[PIP_D-1] && out_ready;

    // Data registers load only with a valid word so out_data holds while idle.
    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < PIP_D; i++) begin
            data_d[i] = data_q[i];
        end
        if (adv[0]) begin
            vld_d[0] = src_vld;
            if (src_vld) begin
                data_d[0] = src_data;
            end
        end
        for (int i = 1; i < PIP_D; i++) begin
            if (adv[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
        count_d = count_q + CW'(in_fire) - CW'(out_fire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < PIP_D; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            for (int i = 0; i < PIP_D; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_data  = data_q[PIP_D-1];
    assign out_valid = vld_q[PIP_D-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_elastic.sv
// Bench for pipe_elastic (PIP_D=3, REG_W=8): directed scenarios plus randomized run
// against a queue model in which each word becomes visible D-1 edges after it enters stage 0.
module tb_pipe_elastic;
    localparam int D = 3;
    localparam int W = 8;
`ifdef PIPE_ELASTIC_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int NEVER = 32'h3fff_ffff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [$clog2(D+2)-1:0] count;

    int checks = 0;
    int failures = 0;

    // Reference model: ordered words with the edge index from which each may be at the tail.
    logic [W-1:0] m_data[$];
    int           m_elig[$];
    bit           m_skid = 1'b0;
    int           edges = 0;

    pipe_elastic #(.REG_W(W), .PIP_D(D)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic bit m_ov();
        return (m_data.size() > 0) && (edges >= m_elig[0]);
    endfunction

    function automatic bit m_ir();
        if (!rst_n) return 1'b0;
        if (SKID) return !m_skid;
        return (m_data.size() < D) || (m_ov() && out_ready);
    endfunction

    // Advance one clock edge, updating the model from the inputs seen just before the edge.
    task automatic tick();
        bit fin, fout;
        logic [W-1:0] d;
        fout = m_ov() && out_ready;
        fin  = in_valid && m_ir();
        d    = in_data;
        @(posedge clk);
        edges++;
        if (!rst_n) begin
            m_data.delete();
            m_elig.delete();
            m_skid = 1'b0;
        end else begin
            if (fout) begin
                void'(m_data.pop_front());
                void'(m_elig.pop_front());
                if (m_skid) begin
                    m_elig[m_elig.size()-1] = edges + D - 1;
                    m_skid = 1'b0;
                end
            end
            if (fin) begin
                if (SKID && m_data.size() >= D) begin
                    m_elig.push_back(NEVER);
                    m_skid = 1'b1;
                end else begin
                    m_elig.push_back(edges + D - 1);
                end
                m_data.push_back(d);
            end
        end
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (m_data.size() != 0) tick();
        end
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h3C;
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (count !== 0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_low: got %0b expected 0", in_ready); end
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after: got %0b expected 1", in_ready); end
    endtask

    task automatic test_stream();
        int acc = -1, first = -1, last = -1, nxt = 1, peak = 0, bad = 0;
        bit f;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h01;
        for (int c = 0; c < 40; c++) begin
            #1;
            f = in_valid && in_ready;
            if (f && acc < 0) acc = edges + 1;
            tick();
            if (int'(count) > peak) peak = int'(count);
            if (out_valid) begin
                if (first < 0) first = edges;
                last = edges;
                if (out_data !== nxt[W-1:0]) bad++;
                nxt++;
            end
            if (f) begin
                if (in_data == 8'h10) in_valid = 1'b0;
                else in_data = in_data + 8'h01;
            end
        end
        checks++; if (first - acc !== D - 1) begin failures++; $display("FAIL stream_latency: got %0d expected %0d", first - acc, D - 1); end
        checks++; if (last - first !== 15) begin failures++; $display("FAIL stream_throughput: got %0d expected 15", last - first); end
        checks++; if (nxt !== 17) begin failures++; $display("FAIL stream_word_count: got %0d expected 16", nxt - 1); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stream_order: got %0d bad words expected 0", bad); end
        checks++; if (peak !== D) begin failures++; $display("FAIL stream_count_peak: got %0d expected %0d", peak, D); end
        drain();
    endtask

    task automatic test_full_stall();
        logic [W-1:0] ex[4];
        int n, got, bad;
        ex[0] = 8'hA1; ex[1] = 8'hA2; ex[2] = 8'hA3; ex[3] = 8'hA4;
        n = SKID ? 4 : 3;
        out_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        tick(); tick();
        #1;
        checks++; if (count !== 3) begin failures++; $display("FAIL full_count: got %0d expected 3", count); end
        checks++; if (in_ready !== SKID) begin failures++; $display("FAIL full_in_ready: got %0b expected %0b", in_ready, SKID); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin failures++; $display("FAIL full_tail: got v=%0b d=%0h expected v=1 d=a1", out_valid, out_data); end
`ifdef PIPE_ELASTIC_SKID_EN
        push(8'hA4);
        #1;
        checks++; if (count !== 4) begin failures++; $display("FAIL skid_count: got %0d expected 4", count); end
`endif
        in_valid = 1'b1;
        in_data = 8'hEE;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_blocks: got in_ready=%0b expected 0", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (count !== n) begin failures++; $display("FAIL full_no_accept: got %0d expected %0d", count, n); end
        checks++; if (out_data !== 8'hA1) begin failures++; $display("FAIL stall_stable: got %0h expected a1", out_data); end
        out_ready = 1'b1;
        got = 0;
        bad = 0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                if (got >= n || out_data !== ex[got]) bad++;
                got++;
            end
            tick();
        end
        checks++; if (got !== n) begin failures++; $display("FAIL release_count: got %0d words expected %0d", got, n); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL release_order: got %0d bad words expected 0", bad); end
        drain();
    endtask

    task automatic test_collapse();
        out_ready = 1'b0;
        push(8'h55);
        for (int c = 0; c < 8 && !out_valid; c++) tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL collapse_reach_tail: got %0b expected 1", out_valid); end
        tick(); tick();
        push(8'h66);
        tick(); tick(); tick(); tick();
        #1;
        checks++; if (count !== 2) begin failures++; $display("FAIL collapse_count: got %0d expected 2", count); end
        checks++; if (out_data !== 8'h55) begin failures++; $display("FAIL collapse_head: got %0h expected 55", out_data); end
        out_ready = 1'b1;
        #1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin failures++; $display("FAIL collapse_adjacent: got v=%0b d=%0h expected v=1 d=66", out_valid, out_data); end
        checks++; if (count !== 1) begin failures++; $display("FAIL collapse_count_after: got %0d expected 1", count); end
        drain();
    endtask

    task automatic test_full_simul();
        logic [W-1:0] ex[3];
        int got, bad;
        ex[0] = 8'hB2; ex[1] = 8'hB3; ex[2] = 8'hB4;
        out_ready = 1'b0;
        push(8'hB1); push(8'hB2); push(8'hB3);
        tick(); tick();
        #1;
        checks++; if (count !== D) begin failures++; $display("FAIL simul_full: got %0d expected %0d", count, D); end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hB4;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL simul_in_ready: got %0b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (count !== D) begin failures++; $display("FAIL simul_count: got %0d expected %0d", count, D); end
        out_ready = 1'b1;
        got = 0;
        bad = 0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                if (got >= 3 || out_data !== ex[got]) bad++;
                got++;
            end
            tick();
        end
        checks++; if (got !== 3 || bad !== 0) begin failures++; $display("FAIL simul_no_loss: got %0d words %0d bad expected 3 words 0 bad", got, bad); end
        drain();
    endtask

    task automatic test_reset_mid();
        int acc, vis;
        logic [W-1:0] dat;
        out_ready = 1'b0;
        push(8'hC1); push(8'hC2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (count !== 0) begin failures++; $display("FAIL midreset_count: got %0d expected 0", count); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL midreset_out_data: got %0h expected 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready: got %0b expected 1", in_ready); end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h7E;
        #1;
        acc = edges + 1;
        tick();
        in_valid = 1'b0;
        vis = -1;
        dat = '0;
        for (int c = 0; c < 10; c++) begin
            if (vis < 0 && out_valid) begin
                vis = edges;
                dat = out_data;
            end
            tick();
        end
        checks++; if (vis - acc !== D - 1) begin failures++; $display("FAIL midreset_latency: got %0d expected %0d", vis - acc, D - 1); end
        checks++; if (dat !== 8'h7E) begin failures++; $display("FAIL midreset_word: got %0h expected 7e", dat); end
        drain();
    endtask

    task automatic test_random();
        bit hold = 1'b0;
        logic [W-1:0] hold_data = '0;
        for (int c = 0; c < 8000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = W'($urandom);
            out_ready = ((c / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (out_valid !== m_ov()) begin failures++; $display("FAIL rand_out_valid cyc %0d: got %0b expected %0b", c, out_valid, m_ov()); end
            checks++; if (in_ready !== m_ir()) begin failures++; $display("FAIL rand_in_ready cyc %0d: got %0b expected %0b", c, in_ready, m_ir()); end
            checks++; if (int'(count) !== m_data.size()) begin failures++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", c, count, m_data.size()); end
            if (m_ov()) begin
                checks++; if (out_data !== m_data[0]) begin failures++; $display("FAIL rand_out_data cyc %0d: got %0h expected %0h", c, out_data, m_data[0]); end
            end
            if (hold) begin
                checks++; if (out_data !== hold_data) begin failures++; $display("FAIL rand_hold cyc %0d: got %0h expected %0h", c, out_data, hold_data); end
            end
            hold = out_valid && !out_ready;
            hold_data = out_data;
            tick();
        end
        drain();
        checks++; if (count !== 0) begin failures++; $display("FAIL rand_final_count: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_collapse();
        test_full_simul();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
